// File: rtl/otter_cu_fsm_mc_if.sv
// Control-unit bus: decoder/memory/interrupt inputs and the enables the control unit drives.
// The slave side is the control unit and the master side is the datapath/memory environment.
interface otter_cu_fsm_mc_if #(
    parameter int NUM_IRQ = 4
) ();
    localparam int IRQ_ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [31:0]         instrn;
    logic                mem_misalign;
    logic                mem_rdy1;
    logic                mem_rdy2;
    logic [NUM_IRQ-1:0]  irq_vld;
    logic [NUM_IRQ-1:0]  irq_mask;
    logic                irq_en;

    logic                pc_w_en;
    logic                rfile_w_en;
    logic                mem_rden1;
    logic                mem_rden2;
    logic                mem_we2;
    logic                cu_rst;
    logic                csr_we;
    logic                invld_opcode;
    logic                intrpt_taken;
    logic [IRQ_ID_W-1:0] intrpt_id;
    logic [NUM_IRQ-1:0]  irq_pending;

    modport slave (
        input  instrn, mem_misalign, mem_rdy1, mem_rdy2, irq_vld, irq_mask, irq_en,
        output pc_w_en, rfile_w_en, mem_rden1, mem_rden2, mem_we2, cu_rst, csr_we,
               invld_opcode, intrpt_taken, intrpt_id, irq_pending
    );

    modport master (
        output instrn, mem_misalign, mem_rdy1, mem_rdy2, irq_vld, irq_mask, irq_en,
        input  pc_w_en, rfile_w_en, mem_rden1, mem_rden2, mem_we2, cu_rst, csr_we,
               invld_opcode, intrpt_taken, intrpt_id, irq_pending
    );
endinterface

// File: rtl/otter_cu_fsm_mc.sv
// Multi-cycle OTTER control unit: fetch/exec/load/store/trap sequencing with ready-handshaked memory
// ports and edge-latched, masked, lowest-index-first interrupts taken only at instruction boundaries.
module otter_cu_fsm_mc #(
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    otter_cu_fsm_mc_if.slave   bus
);
    localparam int IRQ_ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_FETCH   = 3'd1,
        S_EXEC    = 3'd2,
        S_LD_WAIT = 3'd3,
        S_WR_BK   = 3'd4,
        S_ST_WAIT = 3'd5,
        S_INTRPT  = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_IRQ-1:0]  pend_q, pend_d, vld_prev_q;
    logic [NUM_IRQ-1:0]  active_s, clr_s;
    logic [IRQ_ID_W-1:0] id_q, id_d, low_id_s;
    logic                take_s, boundary_s;
    logic [6:0]          opcode_s;
    logic                func0_s;
    logic                pc_w_en_s, rfile_w_en_s, mem_rden1_s, mem_rden2_s, mem_we2_s;
    logic                cu_rst_s, csr_we_s, invld_opcode_s, intrpt_taken_s;
    logic                unused_instr_bits;

    assign opcode_s          = bus.instrn[6:0];
    assign func0_s           = bus.instrn[12];
    assign unused_instr_bits = ^{bus.instrn[31:13], bus.instrn[11:7]};

    assign active_s = pend_q & bus.irq_mask;
    assign take_s   = bus.irq_en & (|active_s);

    // Lowest enabled pending line wins: scan high to low so the last hit is the smallest index.
    always_comb begin
        low_id_s = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            low_id_s = active_s[i] ? IRQ_ID_W'(i) : low_id_s;
        end
    end

    // Next-state and control decode; a boundary arm picks INTRPT or FETCH directly.
    always_comb begin
        state_d        = state_q;
        boundary_s     = 1'b0;
        pc_w_en_s      = 1'b1;
        rfile_w_en_s   = 1'b0;
        mem_rden1_s    = 1'b0;
        mem_rden2_s    = 1'b0;
        mem_we2_s      = 1'b0;
        cu_rst_s       = 1'b0;
        csr_we_s       = 1'b0;
        invld_opcode_s = 1'b0;
        intrpt_taken_s = 1'b0;
        case (state_q)
            S_INIT: begin
                cu_rst_s  = 1'b1;
                pc_w_en_s = 1'b0;
                state_d   = S_FETCH;
            end
            S_FETCH: begin
                mem_rden1_s = 1'b1;
                pc_w_en_s   = 1'b0;
                state_d     = bus.mem_rdy1 ? S_EXEC : S_FETCH;
            end
            S_EXEC: begin
                boundary_s = 1'b1;
                state_d    = take_s ? S_INTRPT : S_FETCH;
                case (opcode_s)
                    OPC_OP, OPC_OP_IMM, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_JAL: rfile_w_en_s = 1'b1;
                    OPC_SYS: begin
                        rfile_w_en_s = func0_s;
                        csr_we_s     = func0_s;
                    end
                    OPC_BRANCH: pc_w_en_s = 1'b1;
                    OPC_LOAD: begin
                        if (!bus.mem_misalign) begin
                            mem_rden2_s = 1'b1;
                            pc_w_en_s   = 1'b0;
                            boundary_s  = 1'b0;
                            state_d     = S_LD_WAIT;
                        end else begin
                            mem_rden2_s = 1'b0;
                        end
                    end
                    OPC_STORE: begin
                        if (!bus.mem_misalign && !bus.mem_rdy2) begin
                            mem_we2_s  = 1'b1;
                            pc_w_en_s  = 1'b0;
                            boundary_s = 1'b0;
                            state_d    = S_ST_WAIT;
                        end else begin
                            mem_we2_s = !bus.mem_misalign;
                        end
                    end
                    default: invld_opcode_s = 1'b1;
                endcase
            end
            S_LD_WAIT: begin
                mem_rden2_s = 1'b1;
                pc_w_en_s   = 1'b0;
                state_d     = bus.mem_rdy2 ? S_WR_BK : S_LD_WAIT;
            end
            S_WR_BK: begin
                rfile_w_en_s = 1'b1;
                boundary_s   = 1'b1;
                state_d      = take_s ? S_INTRPT : S_FETCH;
            end
            S_ST_WAIT: begin
                mem_we2_s = 1'b1;
                if (bus.mem_rdy2) begin
                    boundary_s = 1'b1;
                    state_d    = take_s ? S_INTRPT : S_FETCH;
                end else begin
                    pc_w_en_s = 1'b0;
                end
            end
            S_INTRPT: begin
                intrpt_taken_s = 1'b1;
                state_d        = S_FETCH;
            end
            default: begin
                pc_w_en_s = 1'b0;
                state_d   = S_INIT;
            end
        endcase
    end

    assign id_d   = (boundary_s && take_s) ? low_id_s : id_q;
    assign clr_s  = (state_q == S_INTRPT) ? (NUM_IRQ'(1) << id_q) : '0;
    // A fresh rising edge on the line being serviced overrides its clear.
    assign pend_d = (pend_q & ~clr_s) | (bus.irq_vld & ~vld_prev_q);

    // State, interrupt id, pending bits and edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT;
            id_q       <= '0;
            pend_q     <= '0;
            vld_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            pend_q     <= pend_d;
            vld_prev_q <= bus.irq_vld;
        end
    end

    assign bus.pc_w_en      = pc_w_en_s;
    assign bus.rfile_w_en   = rfile_w_en_s;
    assign bus.mem_rden1    = mem_rden1_s;
    assign bus.mem_rden2    = mem_rden2_s;
    assign bus.mem_we2      = mem_we2_s;
    assign bus.cu_rst       = cu_rst_s;
    assign bus.csr_we       = csr_we_s;
    assign bus.invld_opcode = invld_opcode_s;
    assign bus.intrpt_taken = intrpt_taken_s;
    assign bus.intrpt_id    = id_q;
    assign bus.irq_pending  = pend_q;
endmodule
